// File: rtl/gaussian_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gauss_pkg
// Shared definitions for the Gaussian blur stream controller slice:
//   - state_t      : frame sequencer state encoding
//   - IMG_*_DEFAULT: default frame geometry (must match the filter line buffer)
//   - TAPS/BORDER  : kernel length and the resulting border trim
//   - window_primed: true once a 5x5 window ending at (col,row) is fully filled
// -----------------------------------------------------------------------------
package gauss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int IMG_W_DEFAULT = 400;
  localparam int IMG_H_DEFAULT = 300;
  localparam int TAPS          = 5;
  localparam int BORDER        = (TAPS - 1) / 2;

  // The window whose bottom-right sample is (col,row) covers columns
  // col-(TAPS-1)..col and rows row-(TAPS-1)..row; it is only complete once
  // both coordinates have advanced at least TAPS-1 samples into the frame.
  function automatic logic window_primed(input int unsigned col,
                                         input int unsigned row);
    return (col >= 32'(TAPS - 1)) && (row >= 32'(TAPS - 1));
  endfunction

endpackage

// File: rtl/gaussian_stream_ctrl_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column/row position of the next pixel to be accepted in a raster frame.
// Ports:
//   Clk, Reset  : clock, asynchronous active-high reset
//   clear       : synchronous return to (0,0) at frame start
//   advance     : one pixel accepted this cycle
//   col, row    : position of the pixel being presented this cycle
//   last_pixel  : (col,row) is the final pixel of the frame
//   primed      : the filter window ending at (col,row) is fully populated
// -----------------------------------------------------------------------------
module raster_counter
  import gauss_pkg::*;
#(
  parameter int W  = IMG_W_DEFAULT,
  parameter int H  = IMG_H_DEFAULT,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          last_pixel,
  output logic          primed
);

  localparam logic [XW-1:0] COL_LAST = XW'(W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(H - 1);
  localparam logic [XW-1:0] COL_ONE  = XW'(1);
  localparam logic [YW-1:0] ROW_ONE  = YW'(1);

  logic [XW-1:0] col_r;
  logic [YW-1:0] row_r;
  logic          col_wrap_s;
  logic          row_last_s;

  assign col_wrap_s = (col_r == COL_LAST);
  assign row_last_s = (row_r == ROW_LAST);

  // Raster position: column wraps at end of line, row steps on each wrap.
  // Row holds on the final line; the sequencer leaves RUN there and the
  // next frame start clears both counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col_r <= {XW{1'b0}};
      row_r <= {YW{1'b0}};
    end else if (clear) begin
      col_r <= {XW{1'b0}};
      row_r <= {YW{1'b0}};
    end else if (advance) begin
      if (col_wrap_s) begin
        col_r <= {XW{1'b0}};
        if (!row_last_s) begin
          row_r <= row_r + ROW_ONE;
        end
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  assign col        = col_r;
  assign row        = row_r;
  assign last_pixel = col_wrap_s & row_last_s;
  assign primed     = window_primed(32'(col_r), 32'(row_r));

endmodule

// File: rtl/gaussian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// gaussian_stream_ctrl
// Frame sequencer for the separable 5-tap Gaussian blur. Accepts a raster
// pixel stream, advances the external filter only on accepted pixels, drops
// outputs whose 5x5 window is incomplete and registers the rest together
// with their centre coordinates.
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   start               : arms a new frame (honoured only when idle)
//   busy                : sequencer is not idle
//   frame_done          : pulse when the last output of the frame has left
//   in_pixel/valid/ready: source stream handshake
//   filt_din/en/clr     : filter data, clock enable and synchronous clear
//   filt_dout           : combinational filter result for filt_din
//   out_pixel/x/y/last  : blurred pixel, its centre column/row, end-of-frame
//   out_valid/ready     : downstream handshake
// -----------------------------------------------------------------------------
module gaussian_stream_ctrl
  import gauss_pkg::*;
#(
  parameter  int IMG_W = IMG_W_DEFAULT,
  parameter  int IMG_H = IMG_H_DEFAULT,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  input  logic [7:0]    in_pixel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    filt_din,
  output logic          filt_en,
  output logic          filt_clr,
  input  logic [7:0]    filt_dout,
  output logic [7:0]    out_pixel,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  // The filter output for the pixel at (col,row) is the window whose
  // bottom-right corner is that pixel; its centre sits BORDER samples back.
  localparam logic [XW-1:0] X_TRIM = XW'(BORDER);
  localparam logic [YW-1:0] Y_TRIM = YW'(BORDER);

  state_t        state_r;
  state_t        state_s;
  logic          frame_done_s;
  logic          in_ready_s;
  logic          acc_s;
  logic          keep_s;
  logic          ctr_clear_s;

  logic [XW-1:0] col_s;
  logic [YW-1:0] row_s;
  logic          last_pixel_s;
  logic          primed_s;

  logic [7:0]    out_pixel_r;
  logic [XW-1:0] out_x_r;
  logic [YW-1:0] out_y_r;
  logic          out_last_r;
  logic          out_valid_r;

  // A new pixel may only be taken while the output register is free or is
  // being emptied in the same cycle, so a kept result never overwrites an
  // unconsumed one.
  assign in_ready_s  = (state_r == RUN) & (~out_valid_r | out_ready);
  assign acc_s       = in_valid & in_ready_s;
  assign keep_s      = acc_s & primed_s;
  assign ctr_clear_s = (state_r == CLEAR);

  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .XW (XW),
    .YW (YW)
  ) u_raster_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      (ctr_clear_s),
    .advance    (acc_s),
    .col        (col_s),
    .row        (row_s),
    .last_pixel (last_pixel_s),
    .primed     (primed_s)
  );

  // Sequencer state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sequencer next state and frame completion pulse.
  always_comb begin
    state_s      = state_r;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        state_s = RUN;
      end
      RUN: begin
        if (acc_s && last_pixel_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // The frame is finished once the final result is gone (or was never
        // held); signal it in the same cycle it is taken downstream.
        if (!out_valid_r || out_ready) begin
          frame_done_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output register: load a primed window result, otherwise retire the held
  // result once downstream takes it; data holds while stalled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_pixel_r <= 8'd0;
      out_x_r     <= {XW{1'b0}};
      out_y_r     <= {YW{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (keep_s) begin
      out_pixel_r <= filt_dout;
      out_x_r     <= col_s - X_TRIM;
      out_y_r     <= row_s - Y_TRIM;
      out_last_r  <= last_pixel_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_s;
  assign in_ready   = in_ready_s;
  assign filt_din   = in_pixel;
  assign filt_en    = acc_s;
  // Reset clears the filter asynchronously to the sequencer so no stale
  // line-buffer content survives an aborted frame.
  assign filt_clr   = Reset | ctr_clear_s;
  assign out_pixel  = out_pixel_r;
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_last   = out_last_r;
  assign out_valid  = out_valid_r;

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gaussian_stream_ctrl
// Directed bench for gaussian_stream_ctrl on an 8x6 frame. The filter is a
// pass-through (filt_dout = filt_din), source pixel n carries value n, so the
// expected output list follows directly from the border-trim rule.
// -----------------------------------------------------------------------------
module tb_gaussian_stream_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int NPIX = W * H;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic [7:0]    in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    filt_din;
  logic          filt_en;
  logic          filt_clr;
  logic [7:0]    filt_dout;
  logic [7:0]    out_pixel;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  gaussian_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .filt_din   (filt_din),
    .filt_en    (filt_en),
    .filt_clr   (filt_clr),
    .filt_dout  (filt_dout),
    .out_pixel  (out_pixel),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Pass-through filter stand-in.
  assign filt_dout = filt_din;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int pix;
    int last;
  } beat_t;

  beat_t exp_q[$];
  beat_t first_b;
  beat_t last_b;
  int    n_out;
  int    total;
  int    bad;
  int    acc_cyc;
  int    fd_cyc;
  bit    phase_run;
  bit    prev_stall;
  beat_t prev_b;

  logic s_acc, s_fd, s_busy, s_clr, s_rdy, s_en, s_ov;
  int   s_cyc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Model: every pixel whose column and row are both at least TAPS-1 yields
  // one output centred two samples up and left, in raster order.
  task automatic new_frame();
    beat_t b;
    exp_q.delete();
    n_out      = 0;
    fd_cyc     = -1;
    acc_cyc    = -1;
    prev_stall = 1'b0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (c >= 4 && r >= 4) begin
          b.x    = c - 2;
          b.y    = r - 2;
          b.pix  = r * W + c;
          b.last = (c == W - 1 && r == H - 1) ? 1 : 0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Per-cycle comparison of the DUT against the model and handshake rules.
  task automatic compare_cycle();
    beat_t got;
    got.x    = int'(out_x);
    got.y    = int'(out_y);
    got.pix  = int'(out_pixel);
    got.last = int'(out_last);
    chk("filt_en", int'(filt_en), int'(in_valid && in_ready));
    chk("filt_din", int'(filt_din), int'(in_pixel));
    chk("in_ready", int'(in_ready), int'(phase_run && (!out_valid || out_ready)));
    if (prev_stall) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_pix", got.pix, prev_b.pix);
      chk("stall_x", got.x, prev_b.x);
      chk("stall_y", got.y, prev_b.y);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("extra_output");
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_x", got.x, e.x);
        chk("out_y", got.y, e.y);
        chk("out_pixel", got.pix, e.pix);
        chk("out_last", got.last, e.last);
        if (n_out == 0) first_b = got;
        last_b = got;
        n_out++;
      end
    end
    if (frame_done) begin
      chk("fd_all_emitted", exp_q.size(), 0);
      fd_cyc = s_cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_b     = got;
  endtask

  // One clock: drive inputs after the edge, sample and compare mid-cycle.
  task automatic step(input logic v, input logic [7:0] px, input logic ordy, input logic st);
    in_valid  = v;
    in_pixel  = px;
    out_ready = ordy;
    start     = st;
    @(negedge Clk);
    s_acc  = in_valid && in_ready;
    s_fd   = frame_done;
    s_busy = busy;
    s_clr  = filt_clr;
    s_rdy  = in_ready;
    s_en   = filt_en;
    s_ov   = out_valid;
    s_cyc  = cyc;
    compare_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Start pulse in IDLE followed by the single CLEAR cycle.
  task automatic begin_frame();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("idle_busy", int'(s_busy), 0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("clr_pulse", int'(s_clr), 1);
    chk("clr_ready", int'(s_rdy), 0);
    chk("clr_busy", int'(s_busy), 1);
    chk("clr_en", int'(s_en), 0);
  endtask

  // mode 0: out_ready high; mode 1: out_ready toggles every cycle.
  task automatic run_frame(input int mode, input int gap_idx, input int gap_len,
                           input int start_idx, input int stop_at);
    int   idx;
    int   guard;
    int   gap_left;
    logic v;
    logic ordy;
    logic st;
    idx       = 0;
    guard     = 0;
    gap_left  = gap_len;
    phase_run = 1'b1;
    while (idx < NPIX && idx != stop_at && guard < 1000) begin
      v = 1'b1;
      if (idx == gap_idx && gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end
      ordy = (mode == 1) ? guard[0] : 1'b1;
      st   = (idx == start_idx) ? 1'b1 : 1'b0;
      step(v, idx[7:0], ordy, st);
      chk("run_clr", int'(s_clr), 0);
      chk("run_busy", int'(s_busy), 1);
      if (!v) chk("gap_en", int'(s_en), 0);
      if (s_acc) begin
        if (idx == NPIX - 1) acc_cyc = s_cyc;
        idx++;
      end
      guard++;
    end
    phase_run = 1'b0;
    if (guard >= 1000) fail("run_timeout");
  endtask

  // mode 0: out_ready high; 1: toggling; 2: low for 'hold' cycles then high.
  task automatic drain_frame(input int mode, input int hold);
    logic ordy;
    for (int k = 0; k < 64 && fd_cyc < 0; k++) begin
      if (mode == 2) ordy = (k >= hold) ? 1'b1 : 1'b0;
      else if (mode == 1) ordy = k[0];
      else ordy = 1'b1;
      step(1'b0, 8'h00, ordy, 1'b0);
      if (mode == 2 && k < hold) begin
        chk("hold_busy", int'(s_busy), 1);
        chk("hold_fd", int'(s_fd), 0);
        chk("hold_valid", int'(s_ov), 1);
      end
      if (mode == 2 && k == hold) chk("rise_fd", int'(s_fd), 1);
    end
    if (fd_cyc < 0) fail("drain_timeout");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_busy", int'(s_busy), 0);
  endtask

  // Hand-computed pins for an 8x6 frame: 4x2 outputs, first from pixel 36.
  task automatic check_frame_literals(input string tag);
    chk({tag, "_count"}, n_out, 8);
    chk({tag, "_first_x"}, first_b.x, 2);
    chk({tag, "_first_y"}, first_b.y, 2);
    chk({tag, "_first_pix"}, first_b.pix, 36);
    chk({tag, "_first_last"}, first_b.last, 0);
    chk({tag, "_last_x"}, last_b.x, 5);
    chk({tag, "_last_y"}, last_b.y, 3);
    chk({tag, "_last_pix"}, last_b.pix, 47);
    chk({tag, "_last_flag"}, last_b.last, 1);
  endtask

  task automatic reset_midframe();
    Reset = 1'b1;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_clr", int'(filt_clr), 1);
    chk("mr_ready", int'(in_ready), 0);
    chk("mr_en", int'(filt_en), 0);
    @(posedge Clk);
    #1;
    Reset      = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    Reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = 8'h00;
    out_ready = 1'b0;
    phase_run = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_clr", int'(filt_clr), 1);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_en", int'(filt_en), 0);
    chk("rst_fd", int'(frame_done), 0);
    Reset = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("idle_clr", int'(s_clr), 0);
    chk("idle_busy0", int'(s_busy), 0);

    // Frame 1: free-flowing stream; frame_done in the first DRAIN cycle.
    new_frame();
    begin_frame();
    run_frame(0, -1, 0, -1, -1);
    drain_frame(0, 0);
    check_frame_literals("f1");
    chk("f1_fd_lat", fd_cyc - acc_cyc, 1);

    // Frame 2: out_ready toggling every cycle.
    new_frame();
    begin_frame();
    run_frame(1, -1, 0, -1, -1);
    drain_frame(1, 0);
    check_frame_literals("f2");

    // Frame 3: 3-cycle in_valid gap at (5,4), start pulsed mid-run.
    new_frame();
    begin_frame();
    run_frame(0, 4 * W + 5, 3, 20, -1);
    drain_frame(0, 0);
    check_frame_literals("f3");
    chk("f3_fd_lat", fd_cyc - acc_cyc, 1);

    // Frame 4: aborted by Reset at (4,3); frame 5 must then run cleanly.
    new_frame();
    begin_frame();
    run_frame(0, -1, 0, -1, 3 * W + 4);
    reset_midframe();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ar_busy", int'(s_busy), 0);
    chk("ar_clr", int'(s_clr), 0);
    new_frame();
    begin_frame();
    run_frame(0, -1, 0, -1, -1);
    drain_frame(0, 0);
    check_frame_literals("f5");
    chk("f5_fd_lat", fd_cyc - acc_cyc, 1);

    // Frame 6: out_ready held low at frame end for 4 cycles.
    new_frame();
    begin_frame();
    run_frame(0, -1, 0, -1, -1);
    drain_frame(2, 4);
    check_frame_literals("f6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
